// File: rtl/gf_log_domain_muldiv.sv
// GF(2^WIDTH) multiply/divide in the log domain, fed by two registered log ROMs.
// Latency: 2 cycles from operand acceptance to out_valid; throughput 1 op/cycle.
// Backpressure: one enable (out not valid, or out_ready) stalls the ROMs and both stages together.
// Build option: define GF_DIV_EN to add the divide path and out_err; otherwise every op is a multiply.
module gf_log_domain_muldiv #(
  parameter int               WIDTH     = 8,
  parameter int               MODULUS   = 255,
  parameter logic [WIDTH-1:0] ZERO_CODE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             rom_re,
  output logic [WIDTH-1:0] rom_addr_a,
  output logic [WIDTH-1:0] rom_addr_b,
  input  logic [WIDTH-1:0] rom_data_a,
  input  logic [WIDTH-1:0] rom_data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_exp,
  output logic             out_err
);

  localparam logic [WIDTH:0] MOD_W = MODULUS[WIDTH:0];

  logic             w_en;
  logic             r_v1;
  logic             r_za;
  logic             r_zb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_mul;
  logic [WIDTH-1:0] w_res_exp;
  logic             w_res_err;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_exp;
  logic             r_out_err;

  // The ROM output registers behave as part of stage 1, so they share its enable.
  assign w_en       = !r_out_valid | out_ready;
  assign in_ready   = w_en & !reset;
  assign rom_re     = w_en & !reset;
  assign rom_addr_a = in_a;
  assign rom_addr_b = in_b;

  // Stage 1: operand flags registered alongside the ROM lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_za <= 1'b0;
      r_zb <= 1'b0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      r_za <= (in_a == '0);
      r_zb <= (in_b == '0);
    end
  end

  // Exponent sum with a single conditional subtract folds it back into 0..MODULUS-1.
  assign w_sum = {1'b0, rom_data_a} + {1'b0, rom_data_b};
  assign w_mul = (w_sum >= MOD_W) ? (w_sum - MOD_W) : w_sum;

`ifdef GF_DIV_EN
  logic           r_op1;
  logic [WIDTH:0] w_diff;

  // Stage 1 opcode; only meaningful when the divide path exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op1 <= 1'b0;
    end else if (w_en) begin
      r_op1 <= in_op;
    end
  end

  // Exponent difference; a negative difference wraps by adding the group order.
  assign w_diff = (rom_data_a >= rom_data_b) ?
                  ({1'b0, rom_data_a} - {1'b0, rom_data_b}) :
                  ({1'b0, rom_data_a} - {1'b0, rom_data_b} + MOD_W);

  // Result select; zero operands come from the registered compares, not the ROM code.
  always_comb begin
    w_res_exp = w_mul[WIDTH-1:0];
    w_res_err = 1'b0;
    if (r_op1) begin
      w_res_exp = w_diff[WIDTH-1:0];
      if (r_zb) begin
        w_res_exp = ZERO_CODE;
        w_res_err = 1'b1;
      end else if (r_za) begin
        w_res_exp = ZERO_CODE;
      end
    end else if (r_za | r_zb) begin
      w_res_exp = ZERO_CODE;
    end
  end
`else
  logic w_unused_op;
  assign w_unused_op = in_op;

  // Result select for multiply-only builds; any zero operand forces the zero code.
  always_comb begin
    w_res_exp = w_mul[WIDTH-1:0];
    w_res_err = 1'b0;
    if (r_za | r_zb) begin
      w_res_exp = ZERO_CODE;
    end
  end
`endif

  // Stage 2: output register, advances whenever the consumer can take a new result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_exp   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_v1;
      r_out_exp   <= w_res_exp;
      r_out_err   <= w_res_err;
    end
  end

  assign out_valid = r_out_valid;
  assign out_exp   = r_out_exp;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_gf_log_domain_muldiv.sv
// Bench for gf_log_domain_muldiv: registered log ROM model, GF(2^8) reference built
// from polynomial multiplication (0x11D), and a scoreboard of expected results.
// Covers the divide cases when GF_DIV_EN is defined, multiply-only otherwise.
module tb_gf_log_domain_muldiv;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_op;
  logic       rom_re;
  logic [7:0] rom_addr_a;
  logic [7:0] rom_addr_b;
  logic [7:0] rom_data_a;
  logic [7:0] rom_data_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_exp;
  logic       out_err;

  logic [7:0] logt [256];
  logic [8:0] exq [$];
  int         n_checks  = 0;
  int         n_pass    = 0;
  int         delivered = 0;

  gf_log_domain_muldiv dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .rom_re     (rom_re),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_data_a (rom_data_a),
    .rom_data_b (rom_data_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log ROMs with registered outputs that hold while the read enable is low.
  always @(posedge clk) begin
    if (rom_re) begin
      rom_data_a <= logt[rom_addr_a];
      rom_data_b <= logt[rom_addr_b];
    end
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // Reference: {err, exponent} from true field arithmetic, then a log lookup.
  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, logic op);
    logic [7:0] q = {7'd0, op};
`ifdef GF_DIV_EN
    if (op) begin
      if (b == 8'd0) return {1'b1, 8'hFF};
      if (a == 8'd0) return {1'b0, 8'hFF};
      for (int c = 1; c < 256; c++) begin
        if (gmul(c[7:0], b) == a) q = c[7:0];
      end
      return {1'b0, logt[q]};
    end
`endif
    if (a == 8'd0 || b == 8'd0) return {1'b0, 8'hFF};
    return {1'b0, logt[gmul(a, b)]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One clock: sample both handshakes mid-cycle, score them, then cross the edge.
  task automatic cyc(output bit acc);
    logic [8:0] e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("out_has_expected", (exq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        chk("sb_out_exp", {24'd0, out_exp}, {24'd0, e[7:0]});
        chk("sb_out_err", {31'd0, out_err}, {31'd0, e[8]});
        delivered++;
      end
    end
    if (acc) exq.push_back(model(in_a, in_b, in_op));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc(acc);
    chk("drain_sb_empty", exq.size(), 0);
    chk("drain_out_valid", {31'd0, out_valid}, 0);
  endtask

  // Single op with out_ready high: checks 2-cycle latency and a hand-derived result.
  task automatic single(string tag, logic [7:0] a, logic [7:0] b, logic op,
                        logic [7:0] e_exp, logic e_err);
    bit acc;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = 1'b1;
    cyc(acc);
    chk({tag, "_accept"}, {31'd0, acc}, 1);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 0);
    cyc(acc);
    chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 1);
    chk({tag, "_exp"}, {24'd0, out_exp}, {24'd0, e_exp});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, e_err});
    cyc(acc);
  endtask

  function automatic logic [7:0] rnd_sym(bit allow_zero);
    if (allow_zero && $urandom_range(0, 7) == 0) return 8'd0;
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    bit         acc;
    int         sent;
    int         d0;
    logic [7:0] p;

    p = 8'd1;
    for (int i = 0; i < 255; i++) begin
      logt[p] = 8'(i);
      p = p[7] ? ((p << 1) ^ 8'h1D) : (p << 1);
    end
    logt[0] = 8'hFF;

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'h5A;
    in_b      = 8'hC3;
    in_op     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_exp", {24'd0, out_exp}, 0);
    chk("rst_out_err", {31'd0, out_err}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_rom_re", {31'd0, rom_re}, 0);
    chk("rom_addr_a_pass", {24'd0, rom_addr_a}, 32'h5A);
    chk("rom_addr_b_pass", {24'd0, rom_addr_b}, 32'hC3);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);

    single("mul_3x3", 8'd3, 8'd3, 1'b0, 8'd50, 1'b0);
    single("mul_wrap", 8'd7, 8'd14, 1'b0, 8'd142, 1'b0);
    single("mul_zero", 8'd0, 8'd9, 1'b0, 8'hFF, 1'b0);
`ifdef GF_DIV_EN
    single("div_4_2", 8'd4, 8'd2, 1'b1, 8'd1, 1'b0);
    single("div_2_4", 8'd2, 8'd4, 1'b1, 8'd254, 1'b0);
    single("div_by_0", 8'd5, 8'd0, 1'b1, 8'hFF, 1'b1);
    single("div_0_5", 8'd0, 8'd5, 1'b1, 8'hFF, 1'b0);
    single("div_0_0", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);
`else
    single("op1_4_2", 8'd4, 8'd2, 1'b1, 8'd3, 1'b0);
    single("op1_5_0", 8'd5, 8'd0, 1'b1, 8'hFF, 1'b0);
`endif

    // Four back-to-back multiplies with the consumer stalled for three cycles.
    sent      = 0;
    d0        = delivered;
    in_a      = rnd_sym(0);
    in_b      = rnd_sym(0);
    in_op     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid  = (sent < 4);
      out_ready = !(k >= 2 && k <= 4);
      if (k >= 2 && k <= 4) begin
        #1;
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        chk("stall_rom_re", {31'd0, rom_re}, 0);
      end
      cyc(acc);
      if (acc) begin
        sent++;
        in_a = rnd_sym(0);
        in_b = rnd_sym(0);
      end
    end
    chk("bp_sent", sent, 4);
    drain();
    chk("bp_delivered", delivered - d0, 4);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = rnd_sym(0);
    in_b      = rnd_sym(0);
    cyc(acc);
    in_a = rnd_sym(0);
    cyc(acc);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_flight_in_ready", {31'd0, in_ready}, 0);
    cyc(acc);
    chk("rst_flight_out_valid", {31'd0, out_valid}, 0);
    exq.delete();
    reset     = 1'b0;
    out_ready = 1'b1;
    cyc(acc);
    chk("rst_flight_no_stale", {31'd0, out_valid}, 0);
    single("post_rst_2x128", 8'd2, 8'd128, 1'b0, 8'd8, 1'b0);

    // Randomized traffic on both handshakes.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = rnd_sym(1);
      in_b      = rnd_sym(1);
      in_op     = 1'($urandom_range(0, 1));
      cyc(acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
